// File: rtl/awmc_actuator_driver_if.sv
// Signal bundle between the AWMC controller side and the actuator driver.
// The master drives the controller inputs; the slave drives the actuator commands.
interface awmc_actuator_driver_if;
  logic [2:0] stage;
  logic       done;
  logic       pause;
  logic       lid;
  logic       inlet_valve;
  logic       drain_valve;
  logic       motor_en;
  logic       motor_dir;
  logic [3:0] motor_speed;
  logic       door_lock;
  logic       buzzer;
  logic       fault;

  modport master (
    output stage, done, pause, lid,
    input  inlet_valve, drain_valve, motor_en, motor_dir, motor_speed,
           door_lock, buzzer, fault
  );

  modport slave (
    input  stage, done, pause, lid,
    output inlet_valve, drain_valve, motor_en, motor_dir, motor_speed,
           door_lock, buzzer, fault
  );
endinterface

// File: rtl/awmc_actuator_driver.sv
// Maps the AWMC controller stage, done, pause and lid inputs onto the valve, motor, door-lock
// and buzzer commands, with agitation reversal, spin ramp, safe hold and a sticky lid fault.
module awmc_actuator_driver #(
  parameter int unsigned AGITATE_CYC = 8,
  parameter int unsigned DWELL_CYC   = 2,
  parameter int unsigned WASH_SPEED  = 6,
  parameter int unsigned RAMP_CYC    = 4,
  parameter int unsigned SPIN_MAX    = 15,
  parameter int unsigned BUZZ_CYC    = 16
) (
  input logic                   clk,
  input logic                   reset,
  awmc_actuator_driver_if.slave bus
);

  localparam int unsigned CNT_MAX = (AGITATE_CYC > DWELL_CYC) ? AGITATE_CYC : DWELL_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RAMP_W  = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
  localparam int unsigned BUZZ_W  = $clog2(BUZZ_CYC + 1);

  localparam logic [CNT_W-1:0]  AGI_LAST   = CNT_W'(AGITATE_CYC - 1);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_CYC - 1);
  localparam logic [3:0]        SPD_WASH   = 4'(WASH_SPEED);
  localparam logic [3:0]        SPD_MAX    = 4'(SPIN_MAX);
  localparam logic [BUZZ_W-1:0] BUZZ_LOAD  = BUZZ_W'(BUZZ_CYC);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_RSV6  = 3'd6,
    ST_RSV7  = 3'd7
  } stage_e;

  typedef enum logic [2:0] {
    M_OFF,
    M_FWD,
    M_DWELL_F,
    M_REV,
    M_DWELL_R,
    M_SPIN
  } mstate_e;

  stage_e            stage_in, eff_stage, stage_q, stage_d;
  mstate_e           m_q, m_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic [3:0]        lvl_q, lvl_d;
  logic [BUZZ_W-1:0] buzz_q, buzz_d;
  logic              done_q;
  logic              reserved, fault_set, hold, motor_on;

  logic       inlet_q, inlet_d;
  logic       drain_q, drain_d;
  logic       en_q, en_d;
  logic       dir_q, dir_d;
  logic [3:0] speed_q, speed_d;
  logic       lock_q, lock_d;
  logic       buzzer_q, buzzer_d;
  logic       fault_q, fault_d;

  always_comb begin
    stage_in  = stage_e'(bus.stage);
    reserved  = stage_in inside {ST_RSV6, ST_RSV7};
    eff_stage = reserved ? ST_IDLE : stage_in;

    fault_set = (~bus.lid & lock_q & ~bus.pause) | reserved;
    fault_d   = fault_set | (fault_q & (stage_in != ST_IDLE));
    hold      = bus.pause | ~bus.lid | fault_d;

    m_d     = m_q;
    cnt_d   = cnt_q;
    ramp_d  = ramp_q;
    lvl_d   = lvl_q;
    stage_d = stage_q;

    // Hold freezes the FSM and the stage it serves; only the spin level is dropped so the
    // ramp restarts from 1 once the hold releases.
    if (hold) begin
      if (m_q == M_SPIN) begin
        lvl_d  = '0;
        ramp_d = '0;
      end
    end else begin
      stage_d = stage_in;
      if (m_q != M_OFF && stage_in != stage_q) begin
        m_d    = M_OFF;
        cnt_d  = '0;
        ramp_d = '0;
        lvl_d  = '0;
      end else begin
        unique case (m_q)
          M_OFF: begin
            if (eff_stage inside {ST_WASH, ST_RINSE}) begin
              m_d   = M_FWD;
              cnt_d = '0;
            end else if (eff_stage == ST_SPIN) begin
              m_d    = M_SPIN;
              lvl_d  = 4'd1;
              ramp_d = '0;
            end
          end
          M_FWD, M_REV: begin
            if (cnt_q == AGI_LAST) begin
              m_d   = (m_q == M_FWD) ? M_DWELL_F : M_DWELL_R;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          M_DWELL_F, M_DWELL_R: begin
            if (cnt_q == DWELL_LAST) begin
              m_d   = (m_q == M_DWELL_F) ? M_REV : M_FWD;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          M_SPIN: begin
            if (lvl_q == '0) begin
              lvl_d  = 4'd1;
              ramp_d = '0;
            end else if (ramp_q == RAMP_LAST) begin
              ramp_d = '0;
              if (lvl_q < SPD_MAX) lvl_d = lvl_q + 4'd1;
            end else begin
              ramp_d = ramp_q + 1'b1;
            end
          end
          default: m_d = M_OFF;
        endcase
      end
    end

    motor_on = m_d inside {M_FWD, M_REV, M_SPIN};
    en_d     = ~hold & motor_on;
    if (m_d == M_REV)                      dir_d = 1'b1;
    else if (m_d inside {M_FWD, M_SPIN})   dir_d = 1'b0;
    else                                   dir_d = dir_q;

    if (hold)                              speed_d = '0;
    else if (m_d == M_SPIN)                speed_d = lvl_d;
    else if (m_d inside {M_FWD, M_REV})    speed_d = SPD_WASH;
    else                                   speed_d = '0;

    inlet_d = ~hold & (eff_stage inside {ST_FILL, ST_RINSE});
    drain_d = ~hold & (eff_stage inside {ST_DRAIN, ST_SPIN});

    // Unlocking waits for the registered speed to read zero, so the drum has stopped.
    if ((eff_stage == ST_IDLE || bus.pause) && speed_q == '0) lock_d = 1'b0;
    else if (eff_stage != ST_IDLE)                            lock_d = 1'b1;
    else                                                      lock_d = lock_q;

    if (bus.done & ~done_q)  buzz_d = BUZZ_LOAD;
    else if (buzz_q != '0)   buzz_d = buzz_q - 1'b1;
    else                     buzz_d = '0;
    buzzer_d = (buzz_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q      <= M_OFF;
      stage_q  <= ST_IDLE;
      cnt_q    <= '0;
      ramp_q   <= '0;
      lvl_q    <= '0;
      buzz_q   <= '0;
      done_q   <= 1'b0;
      inlet_q  <= 1'b0;
      drain_q  <= 1'b0;
      en_q     <= 1'b0;
      dir_q    <= 1'b0;
      speed_q  <= '0;
      lock_q   <= 1'b0;
      buzzer_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      m_q      <= m_d;
      stage_q  <= stage_d;
      cnt_q    <= cnt_d;
      ramp_q   <= ramp_d;
      lvl_q    <= lvl_d;
      buzz_q   <= buzz_d;
      done_q   <= bus.done;
      inlet_q  <= inlet_d;
      drain_q  <= drain_d;
      en_q     <= en_d;
      dir_q    <= dir_d;
      speed_q  <= speed_d;
      lock_q   <= lock_d;
      buzzer_q <= buzzer_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.inlet_valve = inlet_q;
  assign bus.drain_valve = drain_q;
  assign bus.motor_en    = en_q;
  assign bus.motor_dir   = dir_q;
  assign bus.motor_speed = speed_q;
  assign bus.door_lock   = lock_q;
  assign bus.buzzer      = buzzer_q;
  assign bus.fault       = fault_q;

endmodule
